// File: rtl/mxn_elastic_pipeline.sv
// Multi-lane elastic pipeline: DEPTH stages of CHANNELS x WIDTH data sharing one valid bit,
// with valid/ready backpressure, bubble collapsing, synchronous flush and occupancy count.
module mxn_elastic_pipeline #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CHANNELS*WIDTH-1:0]     in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CHANNELS*WIDTH-1:0]     out_data,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy
);
    localparam int unsigned DW = CHANNELS * WIDTH;
    localparam int unsigned OW = $clog2(DEPTH + 1);

    logic [DEPTH:1]         valid_q, valid_d;
    logic [DEPTH:1][DW-1:0] data_q, data_d;
    logic [DEPTH:1]         en;
    logic [DEPTH:0]         v_in;
    logic [DEPTH:0][DW-1:0] d_in;
    logic [OW-1:0]          occ_d;

    // Stage k may load when it is empty or anything downstream of it can move.
    always_comb begin
        logic acc;
        acc = out_ready;
        for (int k = int'(DEPTH); k >= 1; k--) begin
            acc   = acc | ~valid_q[k];
            en[k] = acc;
        end
    end

    assign in_ready  = en[1] & ~flush;
    assign v_in      = {valid_q, in_valid};
    assign d_in      = {data_q, in_data};
    assign out_valid = valid_q[DEPTH];
    assign out_data  = data_q[DEPTH];

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = '0;
        end else begin
            for (int k = 1; k <= int'(DEPTH); k++) begin
                if (en[k]) begin
                    valid_d[k] = v_in[k-1];
                    // Bubbles leave the data register untouched.
                    if (v_in[k-1]) data_d[k] = d_in[k-1];
                end
            end
        end
        occ_d = '0;
        for (int k = 1; k <= int'(DEPTH); k++) begin
            occ_d = occ_d + OW'(valid_d[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= '0;
            data_q    <= '0;
            occupancy <= '0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            occupancy <= occ_d;
        end
    end
endmodule

// File: tb/tb_mxn_elastic_pipeline.sv
// Bench for mxn_elastic_pipeline: D=4/C=2 and D=1/C=1 instances on shared stimulus, checked
// every cycle against a word/position queue model plus directed literal expectations.
module tb_mxn_elastic_pipeline;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [15:0] in_data;
    logic        ready_a, valid_a, ready_b, valid_b;
    logic [15:0] data_a;
    logic [7:0]  data_b;
    logic [2:0]  occ_a;
    logic [0:0]  occ_b;

    int checks = 0;
    int failures = 0;
    int outs_a = 0;
    logic chk_on = 1'b0;
    logic acc_a, acc_b;

    // Model: per instance, in-flight words oldest first with their stage position.
    int          cnt [2] = '{0, 0};
    int          pos [2][5];
    logic [15:0] dat [2][5];

    always #5 clk = ~clk;

    mxn_elastic_pipeline #(.WIDTH(8), .CHANNELS(2), .DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ready_a),
        .in_data(in_data), .out_valid(valid_a), .out_ready(out_ready), .out_data(data_a),
        .occupancy(occ_a)
    );

    mxn_elastic_pipeline #(.WIDTH(8), .CHANNELS(1), .DEPTH(1)) u_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ready_b),
        .in_data(in_data[7:0]), .out_valid(valid_b), .out_ready(out_ready), .out_data(data_b),
        .occupancy(occ_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Each word advances one stage per edge unless blocked by the word ahead of it.
    task automatic model_step(input int m, input int d, input logic [15:0] mask);
        int lim, nc, p;
        int np [5];
        logic [15:0] nd [5];
        logic rdy;
        rdy = (cnt[m] < d) || out_ready;
        if (rst || flush) begin
            cnt[m] = 0;
            return;
        end
        lim = out_ready ? d + 2 : d + 1;
        nc = 0;
        for (int i = 0; i < cnt[m]; i++) begin
            p = pos[m][i] + 1;
            if (p > lim - 1) p = lim - 1;
            lim = p;
            if (p <= d) begin
                np[nc] = p;
                nd[nc] = dat[m][i];
                nc++;
            end
        end
        if (in_valid && rdy) begin
            np[nc] = 1;
            nd[nc] = in_data & mask;
            nc++;
        end
        cnt[m] = nc;
        for (int i = 0; i < nc; i++) begin
            pos[m][i] = np[i];
            dat[m][i] = nd[i];
        end
    endtask

    always @(posedge clk) begin
        model_step(0, 4, 16'hFFFF);
        model_step(1, 1, 16'h00FF);
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("A.in_ready", 32'(ready_a), 32'(((cnt[0] < 4) || out_ready) && !flush));
            check("A.out_valid", 32'(valid_a), 32'(cnt[0] > 0 && pos[0][0] == 4));
            check("A.occupancy", 32'(occ_a), 32'(cnt[0]));
            if (cnt[0] > 0 && pos[0][0] == 4) check("A.out_data", 32'(data_a), 32'(dat[0][0]));
            check("B.in_ready", 32'(ready_b), 32'(((cnt[1] < 1) || out_ready) && !flush));
            check("B.out_valid", 32'(valid_b), 32'(cnt[1] > 0));
            check("B.occupancy", 32'(occ_b), 32'(cnt[1]));
            if (cnt[1] > 0) check("B.out_data", 32'(data_b), 32'(dat[1][0][7:0]));
            if (valid_a && out_ready) outs_a++;
        end
    end

    task automatic drive(input logic r, input logic fl, input logic iv, input logic ordy,
                         input logic [15:0] d);
        rst = r;
        flush = fl;
        in_valid = iv;
        out_ready = ordy;
        in_data = d;
        #1;
        acc_a = iv & ready_a;
        acc_b = iv & ready_b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, ordy, 16'h0);
    endtask

    function automatic logic [15:0] word(input int i);
        logic [7:0] lo;
        lo = 8'(i);
        return {lo ^ 8'hA5, lo};
    endfunction

    initial begin
        int accepted, lat;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0);
        chk_on = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0);
        check("reset.out_valid", 32'(valid_a), 32'h0);
        check("reset.out_data", 32'(data_a), 32'h0);
        check("reset.occupancy", 32'(occ_a), 32'h0);
        check("reset.out_data_b", 32'(data_b), 32'h0);

        // Stream 0x01..0x10 with no backpressure.
        outs_a = 0;
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, word(i));
            if (i == 1) check("t1.b_first", 32'({valid_b, data_b}), 32'h101);
            if (i == 3) check("t1.a_not_yet", 32'(valid_a), 32'h0);
            if (i == 4) check("t1.a_first", 32'({valid_a, data_a}), 32'h1A401);
        end
        idle(5, 1'b1);
        check("t1.outs", 32'(outs_a), 32'd16);

        // Backpressure fill: exactly DEPTH words accepted.
        accepted = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, word(8'h20 + i));
            accepted += int'(acc_a);
        end
        check("t2.accepted", 32'(accepted), 32'd4);
        check("t2.occupancy", 32'(occ_a), 32'd4);
        check("t2.in_ready_full", 32'(ready_a), 32'h0);
        outs_a = 0;
        idle(6, 1'b1);
        check("t2.drained", 32'(outs_a), 32'd4);

        // Bubbles collapse under backpressure.
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, (i % 2) == 0, 1'b0, word(8'h40 + i));
        check("t3.occupancy", 32'(occ_a), 32'd2);
        check("t3.head", 32'({valid_a, data_a}), 32'({1'b1, word(8'h40)}));
        idle(6, 1'b1);

        // Full pipe with simultaneous in/out transfer.
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, word(8'h50 + i));
        drive(1'b0, 1'b0, 1'b1, 1'b1, word(8'h54));
        check("t4.accept_full", 32'(acc_a), 32'h1);
        check("t4.occupancy", 32'(occ_a), 32'd4);
        idle(6, 1'b1);

        // Flush with 3 words in flight.
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, word(8'h60 + i));
        drive(1'b0, 1'b1, 1'b1, 1'b0, word(8'h63));
        check("t5.in_ready_flush", 32'(acc_a), 32'h0);
        check("t5.out_valid", 32'(valid_a), 32'h0);
        check("t5.occupancy", 32'(occ_a), 32'h0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, word(8'h70));
        lat = 1;
        while (!valid_a && lat < 20) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
            lat++;
        end
        check("t5.latency", 32'(lat), 32'd4);
        idle(4, 1'b1);

        // Reset with flush mid-stream.
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, word(8'h80 + i));
        drive(1'b1, 1'b1, 1'b1, 1'b1, word(8'h83));
        check("t6.out_valid", 32'(valid_a), 32'h0);
        check("t6.out_data", 32'(data_a), 32'h0);
        check("t6.occupancy", 32'(occ_a), 32'h0);
        check("t6.b_out", 32'({valid_b, data_b, occ_b}), 32'h0);
        idle(2, 1'b1);

        // Randomised traffic, with occasional long stalls, flushes and resets.
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 3) != 0,
                  ((i / 50) % 3 == 2) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0),
                  16'($urandom));
        end
        idle(6, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
